fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Shares the single write port of a BRAM byte FIFO (1024 x 8, `write_enable`/`write_data`/`write_ready`) between `NUM_REQ` producers. For example, the CPU I/O store path and the debug monitor both feed the UART TX FIFO. Arbitration is round-robin at packet granularity, so multi-byte messages from one producer are never interleaved with another producer's bytes. A per-grant beat cap bounds starvation. The block sits between the producers and the FIFO instance; the FIFO read side is untouched.

## Interface
- `NUM_REQ`, default 2: number of producers, 2..8.
- `DATA_WIDTH`, default 8: beat width; matches the FIFO data width.
- `MAX_BURST`, default 16: maximum beats per grant, 1..255.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  producer i has a beat on offer.
- `req_data`  in  NUM_REQ*DATA_WIDTH  producer i beat, at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  the offered beat is the final beat of producer i's packet.
- `req_ready`  out  NUM_REQ  beat of producer i accepted this cycle.
- `fifo_write_ready`  in  1  FIFO not full (FIFO `write_ready`).
- `fifo_write_enable`  out  1  drives FIFO `write_enable`.
- `fifo_write_data`  out  DATA_WIDTH  drives FIFO `write_data`.
- `grant_id`  out  max(1,$clog2(NUM_REQ))  currently or last granted producer.
- `busy`  out  1  high while in GRANT.

## Operation
- The FSM has two states, IDLE and GRANT. Registers:
  - `state`
  - `grant_id`
  - `last_grant`
  - `beat_count` (8 bit)
- Reset values:
  - `state` = IDLE, `grant_id` = 0, `last_grant` = NUM_REQ-1, so producer 0 has first priority.
  - `beat_count` = 0, `busy` = 0.
  - While `reset_n` = 0, `fifo_write_enable` = 0 and `req_ready` = 0, independent of state.
- **IDLE:**
  - If any `req_valid` is high, select the first valid producer scanning (last_grant+1), (last_grant+2), … modulo NUM_REQ.
  - Register the selection into `grant_id`, clear `beat_count`, and go to GRANT.
  - No transfer occurs in IDLE.
- **GRANT:**
  - transfer = `req_valid[grant_id]` & `fifo_write_ready`.
  - `fifo_write_enable` = transfer, and `req_ready[grant_id]` = transfer. All other `req_ready` bits are 0.
  - `fifo_write_data` = the `req_data` slice of `grant_id`, driven in every state. Its value is don't-care when `fifo_write_enable` = 0.
  - On transfer, `beat_count` increments.
  - Release the grant on a transfer with `req_last[grant_id]` = 1, or on a transfer that makes `beat_count` equal MAX_BURST (forced release).
  - Release means `last_grant` <= `grant_id` and `state` <= IDLE.
  - If the granted producer drops `req_valid` mid-packet, the grant is held indefinitely. There is no timeout, and other producers wait.
- **Forced release:** the producer's packet continues on its next grant. Its remaining beats may therefore be interleaved with other producers' packets; software bounds packet length to MAX_BURST when atomicity matters.
- **FIFO full:** `fifo_write_ready` = 0 stalls the transfer. The grant and `beat_count` are held, and no beat is dropped or duplicated.
- `req_*` inputs of non-granted producers are ignored. Their valid may rise or fall freely.
- **Reset mid-packet:** return to reset values immediately. A partially written packet remains in the FIFO; the FIFO is normally reset together with the arbiter.

## Timing
- Arbitration latency: `req_valid` rising in IDLE at cycle t gives `busy` = 1 and a possible first write at cycle t+1.
- Write latency: zero within GRANT. The FIFO samples `write_enable`/`write_data` at the same edge at which the producer sees `req_ready`.
- `fifo_write_enable` and `req_ready` are combinational from the registered state, `req_valid` and `fifo_write_ready`. There is no combinational path from `req_data` to any control output.
- Throughput:
  - 1 beat/cycle within a packet.
  - One idle cycle between packets (the IDLE arbitration cycle). Single-beat packets therefore sustain 1 beat per 2 cycles.
- `grant_id` and `busy` are registered. `grant_id` holds its value in IDLE.

## Test plan
- **Round-robin fairness:** after reset, producers 0 and 1 both hold valid, each with 1-beat packets (0xA0.., 0xB0..).
  - Required FIFO order: A0, B0, A1, B1, …
  - `fifo_write_enable` is high every second cycle, and `grant_id` alternates 0, 1, 0, 1.
- **Packet atomicity:** producer 0 offers a 5-beat packet (0x10–0x14, last on 0x14) while producer 1 offers 0x55.
  - Required FIFO order: 10, 11, 12, 13, 14, 55.
  - `req_ready[1]` stays 0 until the cycle after 0x14 is written, plus one arbitration cycle.
- **Forced release:** MAX_BURST = 4. Producer 0 offers 6 beats 0x00–0x05 (last on 0x05); producer 1 offers 0xEE.
  - Required FIFO order: 00, 01, 02, 03, EE, 04, 05.
- **FIFO full back-pressure:** hold `fifo_write_ready` = 0 for 3 cycles mid-packet.
  - No `fifo_write_enable` and no `req_ready` during those cycles.
  - `beat_count` and `grant_id` are unchanged.
  - After the stall, the beats resume with no loss or duplication.
  - With the real FIFO: after 1024 writes with no reads, `write_ready` = 0 and the 1025th beat is held.
- **Producer bubble:** the granted producer drops `req_valid` for 2 cycles mid-packet while producer 1 is valid.
  - The grant is held and producer 1 is not served until the packet's last beat.
- **Reset mid-packet:** assert `reset_n` = 0 after beat 2 of 4.
  - In the reset cycle, `fifo_write_enable` = 0 and `req_ready` = 0.
  - Afterwards `busy` = 0 and `grant_id` = 0, and producer 0 wins the first arbitration.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-granular arbiter sharing one FIFO write port between
// NUM_REQ producers, with a per-grant beat cap to bound starvation.
//
//   state | meaning
//   IDLE  | no grant; pick next valid producer after last_grant
//   GRANT | grant_id owns the write port until last beat or beat cap
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_write_ready,
    output logic                          fifo_write_enable,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0]    BURST_CAP  = 8'(MAX_BURST);
    localparam logic [GW-1:0] LAST_RESET = GW'(NUM_REQ - 1);

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [7:0]      beat_count_q, beat_count_d;

    logic            sel_found;
    logic [GW-1:0]   sel_id;
    int              cand_i;
    logic [GW-1:0]   cand;

    logic            cur_valid;
    logic            cur_last;
    logic            xfer;

    // Rotating priority scan starting just after the last released producer.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand_i    = 0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_i = (int'(last_grant_q) + k) % NUM_REQ;
            cand   = GW'(cand_i);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    // Granted producer's slice; data path kept separate from control.
    always_comb begin
        cur_valid       = 1'b0;
        cur_last        = 1'b0;
        fifo_write_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == GW'(i)) begin
                cur_valid       = req_valid[i];
                cur_last        = req_last[i];
                fifo_write_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Reset gates the handshake combinationally so nothing writes during reset.
    assign xfer              = reset_n && (state_q == GRANT) && cur_valid && fifo_write_ready;
    assign fifo_write_enable = xfer;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = xfer && (grant_id_q == GW'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        beat_count_d = beat_count_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_id_d   = sel_id;
                    beat_count_d = 8'd0;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    beat_count_d = beat_count_q + 8'd1;
                    if (cur_last || (beat_count_q + 8'd1 == BURST_CAP)) begin
                        last_grant_d = grant_id_q;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= LAST_RESET;
            beat_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign grant_id = grant_id_q;
    assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: two instances (default burst cap
// and MAX_BURST=4) share the producer models; dut_sel picks the observed one.
module tb_fifo_write_arbiter;
    localparam int NR = 2;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_last = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic             fifo_write_ready = 1'b1;
    logic             dut_sel = 1'b0;

    logic [NR-1:0] rr_a, rr_b;
    logic          fe_a, fe_b;
    logic [DW-1:0] fd_a, fd_b;
    logic          gi_a, gi_b;
    logic          bz_a, bz_b;

    fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(16)) u_a (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(rr_a), .fifo_write_ready(fifo_write_ready),
        .fifo_write_enable(fe_a), .fifo_write_data(fd_a), .grant_id(gi_a), .busy(bz_a));

    fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) u_b (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(rr_b), .fifo_write_ready(fifo_write_ready),
        .fifo_write_enable(fe_b), .fifo_write_data(fd_b), .grant_id(gi_b), .busy(bz_b));

    wire [NR-1:0] rr = dut_sel ? rr_b : rr_a;
    wire          fe = dut_sel ? fe_b : fe_a;
    wire [DW-1:0] fd = dut_sel ? fd_b : fd_a;
    wire          gi = dut_sel ? gi_b : gi_a;
    wire          bz = dut_sel ? bz_b : bz_a;
    wire [7:0]    bc = dut_sel ? u_b.beat_count_q : u_a.beat_count_q;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] pq [NR][$];
    logic [8:0] exp_q [$];
    logic [NR-1:0] accepted = '0;
    int  wr_cnt, cyc, last_wr_cyc;
    bit  check_gap;
    int  stall_at, bubble_at, stall_left, bubble_left;
    bit  in_stall, in_bubble;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++)
            if (accepted[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        accepted = '0;
        if (stall_left > 0) begin fifo_write_ready = 1'b0; stall_left--; in_stall = 1'b1; end
        else begin fifo_write_ready = 1'b1; in_stall = 1'b0; end
        if (bubble_left > 0) begin bubble_left--; in_bubble = 1'b1; end
        else in_bubble = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (pq[i].size() > 0 && !(in_bubble && i == 0)) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = pq[i][0][7:0];
                req_last[i]           = pq[i][0][8];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    endtask

    task automatic sample();
        logic [8:0] e;
        accepted = rr;
        if (fe) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("write_when_none_expected", {31'd0, fe}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("data", {24'd0, fd}, {24'd0, e[7:0]});
                check("grant_id", {31'd0, gi}, {31'd0, e[8]});
                check("req_ready_on_write", {30'd0, rr}, 32'd1 << e[8]);
            end
            if (check_gap && last_wr_cyc >= 0) check("write_gap", cyc - last_wr_cyc, 32'd2);
            last_wr_cyc = cyc;
            if (wr_cnt == stall_at)  stall_left  = 3;
            if (wr_cnt == bubble_at) bubble_left = 2;
        end else begin
            check("req_ready_no_write", {30'd0, rr}, 32'd0);
        end
        if (in_stall) begin
            check("stall_beat_count", {24'd0, bc}, 32'd2);
            check("stall_grant_id", {31'd0, gi}, 32'd0);
            check("stall_busy", {31'd0, bz}, 32'd1);
        end
        if (in_bubble) begin
            check("bubble_grant_id", {31'd0, gi}, 32'd0);
            check("bubble_busy", {31'd0, bz}, 32'd1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        cyc++;
        @(negedge clk);
        sample();
    endtask

    task automatic load(input int p, input logic [7:0] base, input int n, input bit push_exp);
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            d = base + 8'(k);
            pq[p].push_back({(k == n - 1), d});
            if (push_exp) exp_q.push_back({1'(p), d});
        end
    endtask

    task automatic exp_push(input int p, input logic [7:0] d);
        exp_q.push_back({1'(p), d});
    endtask

    task automatic begin_test();
        wr_cnt = 0; last_wr_cyc = -1; check_gap = 1'b0;
        stall_at = -1; bubble_at = -1; stall_left = 0; bubble_left = 0;
    endtask

    task automatic run(input int max_cycles, input bit exp_only);
        int n = 0;
        while (n < max_cycles &&
               !(exp_q.size() == 0 && (exp_only || (pq[0].size() == 0 && pq[1].size() == 0)))) begin
            tick();
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);
        if (!exp_only) repeat (3) tick();
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) pq[i].delete();
        exp_q.delete();
        begin_test();
        reset_n = 1'b0;
        tick();
        check("reset_we", {31'd0, fe}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_busy", {31'd0, bz}, 32'd0);
        check("post_reset_grant", {31'd0, gi}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc = 0;
        begin_test();

        // round robin on single-beat packets
        dut_sel = 1'b0;
        do_reset();
        check_gap = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pq[0].push_back({1'b1, 8'hA0 + 8'(k)});
            pq[1].push_back({1'b1, 8'hB0 + 8'(k)});
            exp_push(0, 8'hA0 + 8'(k));
            exp_push(1, 8'hB0 + 8'(k));
        end
        run(100, 1'b0);

        // packet atomicity
        do_reset();
        load(0, 8'h10, 5, 1'b1);
        load(1, 8'h55, 1, 1'b1);
        run(100, 1'b0);

        // forced release at MAX_BURST=4
        dut_sel = 1'b1;
        do_reset();
        load(0, 8'h00, 6, 1'b0);
        load(1, 8'hEE, 1, 1'b0);
        for (int k = 0; k < 4; k++) exp_push(0, 8'(k));
        exp_push(1, 8'hEE);
        exp_push(0, 8'h04);
        exp_push(0, 8'h05);
        run(100, 1'b0);
        dut_sel = 1'b0;

        // FIFO full stall after beat 2
        do_reset();
        stall_at = 2;
        load(0, 8'h20, 4, 1'b1);
        run(100, 1'b0);

        // producer bubble after beat 2 while producer 1 waits
        do_reset();
        bubble_at = 2;
        load(0, 8'h30, 4, 1'b1);
        load(1, 8'h77, 1, 1'b1);
        run(100, 1'b0);

        // reset in the middle of producer 1's packet
        do_reset();
        load(0, 8'h40, 1, 1'b1);
        load(1, 8'h60, 4, 1'b0);
        exp_push(1, 8'h60);
        exp_push(1, 8'h61);
        run(100, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive();
        @(negedge clk);
        check("midpkt_reset_we", {31'd0, fe}, 32'd0);
        check("midpkt_reset_ready", {30'd0, rr}, 32'd0);
        accepted = '0;
        for (int i = 0; i < NR; i++) pq[i].delete();
        tick();
        reset_n = 1'b1;
        tick();
        check("midpkt_post_busy", {31'd0, bz}, 32'd0);
        check("midpkt_post_grant", {31'd0, gi}, 32'd0);
        begin_test();
        load(0, 8'h50, 1, 1'b1);
        load(1, 8'h70, 1, 1'b1);
        run(100, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
